// File: rtl/r_cpu_sequencer.sv
// r_cpu_sequencer: multi-cycle fetch/decode/execute/writeback sequencer for an
// R-type-only core. Drives ROM, PC and register-file strobes from an 8-state
// Moore FSM. Every strobe is a flop that is loaded from the next state, so no
// input reaches an output combinationally.
// Optional feature: define SEQ_RETIRE_COUNT_EN to add the 32-bit
// retired-instruction counter output "retired".
module r_cpu_sequencer #(
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int          ROM_LAT   = 1
) (
    input  logic        clka,
    input  logic        rsta,
    input  logic        start,
    input  logic        step_mode,
    input  logic        step,
    input  logic [31:0] instr,
    output logic        rom_en,
    output logic        pc_en,
    output logic        rf_we,
    output logic [5:0]  alu_op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic        busy,
    output logic        halted,
    output logic        illegal
`ifdef SEQ_RETIRE_COUNT_EN
    ,
    output logic [31:0] retired
`endif
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_DECODE = 3'd3;
    localparam logic [2:0] ST_EXEC   = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_PAUSE  = 3'd6;
    localparam logic [2:0] ST_HALT   = 3'd7;

    // WAIT is entered with this count and leaves when it reaches zero,
    // giving exactly ROM_LAT cycles in WAIT.
    localparam logic [1:0] WAIT_LAST = 2'(ROM_LAT - 1);

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [1:0]  wait_cnt_r;
    logic [1:0]  wait_nxt_s;
    logic [31:0] ir_r;
    logic [31:0] ir_nxt_s;
    logic        illegal_set_s;

    logic        rom_en_r;
    logic        pc_en_r;
    logic        rf_we_r;
    logic        busy_r;
    logic        halted_r;
    logic        illegal_r;

    // True when the word carries an R-type (all-zero) opcode.
    function automatic logic is_rtype(input logic [31:0] word);
        return (word[31:26] == 6'd0);
    endfunction

    // True when the word should write the register file (R-type, rd not r0).
    function automatic logic writes_rf(input logic [31:0] word);
        return is_rtype(word) && (word[15:11] != 5'd0);
    endfunction

    // Next-state, wait-counter and IR-load decisions.
    always_comb begin
        state_nxt_s = state_r;
        wait_nxt_s  = wait_cnt_r;
        ir_nxt_s    = ir_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_nxt_s = ST_WAIT;
                wait_nxt_s  = WAIT_LAST;
            end
            ST_WAIT: begin
                if (wait_cnt_r == 2'd0) begin
                    state_nxt_s = ST_DECODE;
                end else begin
                    wait_nxt_s = wait_cnt_r - 2'd1;
                end
            end
            ST_DECODE: begin
                state_nxt_s = ST_EXEC;
                ir_nxt_s    = instr;
            end
            ST_EXEC: begin
                if (ir_r == HALT_WORD) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_WB;
                end
            end
            ST_WB: begin
                if (step_mode) begin
                    state_nxt_s = ST_PAUSE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_PAUSE: begin
                if (step || !step_mode) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Flags a non-R-type word that is not the halt word while it executes.
    always_comb begin
        illegal_set_s = 1'b0;
        if ((state_r == ST_EXEC) && !is_rtype(ir_r) && (ir_r != HALT_WORD)) begin
            illegal_set_s = 1'b1;
        end else begin
            illegal_set_s = 1'b0;
        end
    end

    // State, wait counter and instruction register.
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 2'd0;
            ir_r       <= 32'd0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_nxt_s;
            ir_r       <= ir_nxt_s;
        end
    end

    // Output strobes registered from the state being entered.
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            rom_en_r  <= 1'b0;
            pc_en_r   <= 1'b0;
            rf_we_r   <= 1'b0;
            busy_r    <= 1'b0;
            halted_r  <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            rom_en_r  <= (state_nxt_s == ST_FETCH);
            pc_en_r   <= (state_nxt_s == ST_WB);
            rf_we_r   <= (state_nxt_s == ST_WB) && writes_rf(ir_nxt_s);
            busy_r    <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_HALT);
            halted_r  <= (state_nxt_s == ST_HALT);
            illegal_r <= illegal_r | illegal_set_s;
        end
    end

    assign rom_en  = rom_en_r;
    assign pc_en   = pc_en_r;
    assign rf_we   = rf_we_r;
    assign busy    = busy_r;
    assign halted  = halted_r;
    assign illegal = illegal_r;

    // Instruction fields come straight from IR and hold until the next load.
    assign alu_op = ir_r[5:0];
    assign rs     = ir_r[25:21];
    assign rt     = ir_r[20:16];
    assign rd     = ir_r[15:11];

`ifdef SEQ_RETIRE_COUNT_EN
    logic [31:0] retired_r;

    // Counts writeback cycles; wraps naturally at 32 bits.
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            retired_r <= 32'd0;
        end else if (state_r == ST_WB) begin
            retired_r <= retired_r + 32'd1;
        end else begin
            retired_r <= retired_r;
        end
    end

    assign retired = retired_r;
`else
`endif

endmodule

// File: tb/tb_r_cpu_sequencer.sv
// Self-checking bench for r_cpu_sequencer. A cycle-timeline reference model
// predicts every strobe from the program contents and the per-instruction
// cycle count (ROM_LAT + 4); a second instance checks ROM_LAT = 3 timing.
module tb_r_cpu_sequencer;

    localparam int          LAT  = 1;
    localparam int          P    = LAT + 4;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic        rsta = 1'b1;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic [31:0] instr;
    logic        rom_en, pc_en, rf_we, busy, halted, illegal;
    logic [5:0]  alu_op;
    logic [4:0]  rs, rt, rd;

    logic        start3 = 1'b0;
    logic [31:0] instr3 = 32'd0;
    logic        rom_en3, pc_en3, rf_we3, busy3, halted3, illegal3;
    logic [5:0]  alu_op3;
    logic [4:0]  rs3, rt3, rd3;

`ifdef SEQ_RETIRE_COUNT_EN
    logic [31:0] retired;
    logic [31:0] retired3;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] rom [0:15];
    int          n_prog;
    logic [31:0] pc;
    logic [31:0] pipe [0:2];

    r_cpu_sequencer #(.HALT_WORD(HALT), .ROM_LAT(LAT)) u_dut (
        .clka(clka), .rsta(rsta), .start(start), .step_mode(step_mode), .step(step),
        .instr(instr), .rom_en(rom_en), .pc_en(pc_en), .rf_we(rf_we), .alu_op(alu_op),
        .rs(rs), .rt(rt), .rd(rd), .busy(busy), .halted(halted), .illegal(illegal)
`ifdef SEQ_RETIRE_COUNT_EN
        , .retired(retired)
`endif
    );

    r_cpu_sequencer #(.HALT_WORD(HALT), .ROM_LAT(3)) u_lat3 (
        .clka(clka), .rsta(rsta), .start(start3), .step_mode(1'b0), .step(1'b0),
        .instr(instr3), .rom_en(rom_en3), .pc_en(pc_en3), .rf_we(rf_we3), .alu_op(alu_op3),
        .rs(rs3), .rt(rt3), .rd(rd3), .busy(busy3), .halted(halted3), .illegal(illegal3)
`ifdef SEQ_RETIRE_COUNT_EN
        , .retired(retired3)
`endif
    );

    // Program counter of the environment, advanced by pc_en.
    always @(posedge clka or negedge rsta) begin
        if (!rsta) pc <= 32'd0;
        else if (pc_en) pc <= pc + 32'd1;
    end

    // ROM with LAT-cycle read latency; data holds until the next read.
    always @(posedge clka) begin
        if (rom_en) pipe[0] <= rom[pc[3:0]];
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign instr = pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic do_reset();
        rsta = 1'b0;
        start = 1'b0;
        start3 = 1'b0;
        step = 1'b0;
        tick();
        tick();
        rsta = 1'b1;
        tick();
    endtask

    function automatic bit is_illegal(input logic [31:0] w);
        return (w[31:26] != 6'd0) && (w != HALT);
    endfunction

    // Runs rom[0..n_prog-1] (last word HALT) with step_mode=0 and checks
    // every cycle against the timeline: instruction k occupies cycles
    // k*P .. k*P+P-1 counted from the first FETCH.
    task automatic run_prog(input string name);
        int h;
        int last_c;
        int pulses;
        int k;
        int o;
        logic [31:0] w;
        bit e_rom, e_pc, e_we, e_busy, e_halt, e_ill;
        h = n_prog - 1;
        last_c = h * P + P + 2;
        pulses = 0;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= last_c; c++) begin
            e_ill = 1'b0;
            if (c >= h * P + P - 1) begin
                e_rom = 1'b0; e_pc = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_halt = 1'b1;
                for (int j = 0; j < h; j++) if (is_illegal(rom[j])) e_ill = 1'b1;
                o = -1;
                w = HALT;
            end else begin
                k = c / P;
                o = c % P;
                w = rom[k];
                e_rom  = (o == 0);
                e_pc   = (o == P - 1);
                e_we   = (o == P - 1) && (w[31:26] == 6'd0) && (w[15:11] != 5'd0);
                e_busy = 1'b1;
                e_halt = 1'b0;
                for (int j = 0; j < k; j++) if (is_illegal(rom[j])) e_ill = 1'b1;
                if ((o == P - 1) && is_illegal(w)) e_ill = 1'b1;
            end
            chk($sformatf("%s c%0d rom_en", name, c), 32'(rom_en), 32'(e_rom));
            chk($sformatf("%s c%0d pc_en", name, c), 32'(pc_en), 32'(e_pc));
            chk($sformatf("%s c%0d rf_we", name, c), 32'(rf_we), 32'(e_we));
            chk($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(e_busy));
            chk($sformatf("%s c%0d halted", name, c), 32'(halted), 32'(e_halt));
            chk($sformatf("%s c%0d illegal", name, c), 32'(illegal), 32'(e_ill));
            if (o == P - 2) begin
                chk($sformatf("%s c%0d fields", name, c), {6'd0, alu_op, rs, rt, rd, 5'd0},
                    {6'd0, w[5:0], w[25:21], w[20:16], w[15:11], 5'd0});
            end
            if (pc_en) pulses++;
            tick();
        end
        chk($sformatf("%s pc_en_pulses", name), 32'(pulses), 32'(h));
        chk($sformatf("%s pc", name), pc, 32'(h));
    endtask

    initial begin
        int gap;
        int pc_off;
        logic [31:0] w;
        for (int i = 0; i < 3; i++) pipe[i] = 32'd0;
        for (int i = 0; i < 16; i++) rom[i] = 32'd0;

        // Reset state.
        #1 rsta = 1'b0;
        #1;
        chk("rst outputs", {26'd0, rom_en, pc_en, rf_we, busy, halted, illegal}, 32'd0);
        chk("rst fields", {11'd0, alu_op, rs, rt, rd}, 32'd0);
        tick();
        rsta = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle after reset", {30'd0, busy, rom_en}, 32'd0);
        end

        // Two adds then HALT; start afterwards must be ignored.
        rom[0] = 32'h0022_1820; rom[1] = 32'h0022_1820; rom[2] = HALT; n_prog = 3;
        run_prog("add_halt");
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("halt start ignored", {29'd0, halted, busy, rom_en}, 32'd4);
            tick();
        end

        // Illegal opcode, then a valid add, then HALT.
        rom[0] = 32'h8C01_0004; rom[1] = 32'h0022_1820; rom[2] = HALT; n_prog = 3;
        run_prog("illegal");

        // NOP then HALT.
        rom[0] = 32'h0000_0000; rom[1] = HALT; n_prog = 2;
        run_prog("nop");

        // Random programs.
        for (int r = 0; r < 4; r++) begin
            n_prog = $urandom_range(2, 6);
            for (int i = 0; i < n_prog - 1; i++) begin
                w = $urandom();
                if ($urandom_range(0, 3) == 0) w[31:26] = 6'($urandom_range(1, 62));
                else w[31:26] = 6'd0;
                if ($urandom_range(0, 4) == 0) w[15:11] = 5'd0;
                rom[i] = w;
            end
            rom[n_prog - 1] = HALT;
            run_prog($sformatf("rand%0d", r));
        end

        // Single-step mode.
        rom[0] = 32'h0022_1820; rom[1] = 32'h00A4_3020; rom[2] = 32'h0022_1820; rom[3] = HALT;
        do_reset();
        step_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("step first rom_en", 32'(rom_en), 32'd1);
        repeat (P - 1) tick();
        chk("step wb1", {30'd0, pc_en, rf_we}, 32'd3);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("step pause1", {29'd0, rom_en, pc_en, busy}, 32'd1);
            tick();
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("step released rom_en", 32'(rom_en), 32'd1);
        repeat (P - 2) tick();
        chk("step exec rd", {21'd0, alu_op, rd}, {21'd0, 6'h20, 5'd6});
        tick();
        chk("step wb2", {30'd0, pc_en, rf_we}, 32'd3);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("step pause2", {29'd0, rom_en, pc_en, busy}, 32'd1);
            tick();
        end
        step_mode = 1'b0;
        tick();
        chk("step_mode off resumes", 32'(rom_en), 32'd1);
        gap = 0;
        while (!halted && gap < 40) begin
            tick();
            gap++;
        end
        chk("step run to halt", 32'(halted), 32'd1);
        chk("step pc", pc, 32'd3);

        // Reset asserted in EXEC with a register write pending.
        rom[0] = 32'h0022_1820; rom[1] = HALT;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (P - 2) tick();
        chk("midrst exec rd", 32'(rd), 32'd3);
        rsta = 1'b0;
        #1;
        chk("midrst outputs", {26'd0, rom_en, pc_en, rf_we, busy, halted, illegal}, 32'd0);
        chk("midrst fields", {11'd0, alu_op, rs, rt, rd}, 32'd0);
        tick();
        chk("midrst no strobe", {29'd0, pc_en, rf_we, busy}, 32'd0);
        rsta = 1'b1;
        tick();
        tick();
        chk("midrst stays idle", {30'd0, busy, rom_en}, 32'd0);

        // ROM_LAT = 3 instance: 7 cycles per instruction.
        do_reset();
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk("lat3 rom_en", 32'(rom_en3), 32'd1);
        gap = 0;
        pc_off = -1;
        while (gap < 20) begin
            tick();
            gap++;
            if (pc_en3 && pc_off < 0) pc_off = gap;
            if (rom_en3) break;
        end
        chk("lat3 period", 32'(gap), 32'd7);
        chk("lat3 pc_en offset", 32'(pc_off), 32'd6);

`ifdef SEQ_RETIRE_COUNT_EN
        // Retired counter wraps from all-ones to zero on one writeback.
        rom[0] = 32'h0022_1820; rom[1] = HALT;
        do_reset();
        force u_dut.retired_r = 32'hFFFF_FFFF;
        tick();
        release u_dut.retired_r;
        chk("retired preload", retired, 32'hFFFF_FFFF);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (P) tick();
        chk("retired wrap", retired, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
